ym3438_clk_gen: RTL and testbench

- Master timing generator for the OPN2 core; sits directly upstream of every shift-register, counter and latch primitive.
- Divides MCLK into the two non-overlapping single-MCLK enable pulses c1/c2 that those primitives consume.
- Maintains the global slot counter (0..SLOTS-1) that sequences the 24-slot operator pipeline.
- Synchronises the chip-clear (IC) pin into the c1/c2 domain.

---
 rtl/ym3438_clk_gen.sv | 86 ++++++++
 tb/tb_ym3438_clk_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ym3438_clk_gen.sv
// ym3438_clk_gen: master timing generator for the OPN2 core.
// Divides MCLK into non-overlapping c1/c2 enable pulses, keeps the global
// slot counter that sequences the operator pipeline, and brings the chip
// clear pin into the c1/c2 domain.
`timescale 1ns/1ps

module ym3438_clk_gen #(
  parameter int DIV    = 6,
  parameter int SLOTS  = 24,
  parameter int SLOT_W = 5
) (
  input  logic              MCLK,
  input  logic              reset,
  input  logic              ic,
  output logic              c1,
  output logic              c2,
  output logic [SLOT_W-1:0] slot,
  output logic              slot_last,
  output logic              ic_sync
);

  // Prescaler needs at least one bit even when DIV == 2.
  localparam int P_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [P_W-1:0]    P_LAST    = P_W'(DIV - 1);
  localparam logic [P_W-1:0]    P_HALF    = P_W'(DIV / 2 - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

  logic [P_W-1:0]    p_q, p_d;
  logic              c1_q, c1_d;
  logic              c2_q, c2_d;
  logic              s0_q, s0_d;
  logic              s1_q, s1_d;
  logic              ic_sync_q, ic_sync_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  // Next-state logic. c1/c2 are decoded one count early so the registered
  // pulses land on p == 0 and p == DIV/2 respectively.
  always_comb begin
    p_d       = (p_q == P_LAST) ? '0 : p_q + P_W'(1);
    c1_d      = (p_q == P_LAST);
    c2_d      = (p_q == P_HALF);
    s0_d      = ic;
    s1_d      = s0_q;
    ic_sync_d = c1_q ? s1_q : ic_sync_q;
    slot_d    = slot_q;
    if (c2_q) begin
      // Clear wins over the wrap when both apply.
      if (ic_sync_q) begin
        slot_d = '0;
      end else if (slot_q == SLOT_LAST) begin
        slot_d = '0;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end
  end

  // State registers; reset clears everything immediately, mid-pulse included.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      p_q       <= '0;
      c1_q      <= 1'b0;
      c2_q      <= 1'b0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      ic_sync_q <= 1'b0;
      slot_q    <= '0;
    end else begin
      p_q       <= p_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      ic_sync_q <= ic_sync_d;
      slot_q    <= slot_d;
    end
  end

  assign c1        = c1_q;
  assign c2        = c2_q;
  assign slot      = slot_q;
  assign slot_last = (slot_q == SLOT_LAST);
  assign ic_sync   = ic_sync_q;

endmodule

// File: tb/tb_ym3438_clk_gen.sv
// Directed bench for ym3438_clk_gen: default instance (DIV=6, SLOTS=24) plus
// a small instance (DIV=2, SLOTS=4) sharing clock and reset.
`timescale 1ns/1ps

module tb_ym3438_clk_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ic  = 1'b0;
  logic       ic_b = 1'b0;

  logic       c1, c2, slot_last, ic_sync;
  logic [4:0] slot;
  logic       c1_b, c2_b, slot_last_b, ic_sync_b;
  logic [1:0] slot_b;

  int checks = 0;
  int errors = 0;
  int n      = 0;  // MCLK edges since the last reset release

  always #5 clk = ~clk;

  ym3438_clk_gen dut (
    .MCLK(clk), .reset(rst), .ic(ic),
    .c1(c1), .c2(c2), .slot(slot), .slot_last(slot_last), .ic_sync(ic_sync)
  );

  ym3438_clk_gen #(.DIV(2), .SLOTS(4), .SLOT_W(2)) dut_small (
    .MCLK(clk), .reset(rst), .ic(ic_b),
    .c1(c1_b), .c2(c2_b), .slot(slot_b), .slot_last(slot_last_b), .ic_sync(ic_sync_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  // Expected slot for the default instance during the ic scenarios.
  function automatic int slot_exp_ic(input int k);
    if (k < 208)      return ((k + 2) / 6) % 24;
    else if (k < 214) return 11;
    else if (k < 232) return 0;
    else              return (1 + (k - 232) / 6) % 24;
  endfunction

  task automatic check_cycle(input int exp_slot, input int exp_ics);
    chk("c2",           c2,          (n % 6 == 3));
    chk("c1",           c1,          (n > 0 && n % 6 == 0));
    chk("c1c2_excl",    c1 & c2,     0);
    chk("slot",         slot,        exp_slot);
    chk("slot_last",    slot_last,   (exp_slot == 23));
    chk("ic_sync",      ic_sync,     exp_ics);
    chk("c2_small",     c2_b,        (n % 2 == 1));
    chk("c1_small",     c1_b,        (n > 0 && n % 2 == 0));
    chk("slot_small",   slot_b,      (n / 2) % 4);
    chk("slot_last_sm", slot_last_b, ((n / 2) % 4 == 3));
    chk("ic_sync_sm",   ic_sync_b,   0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check_cycle(0, 0);
    $display("step reset_hold: n=%0d slot=%0d c1=%0b c2=%0b", n, slot, c1, c2);

    // Release and free-run through a full slot lap and beyond, to slot 10.
    rst = 1'b0;
    n   = 0;
    while (n < 203) begin
      tick();
      check_cycle(((n + 2) / 6) % 24, 0);
    end
    $display("step free_run: n=%0d slot=%0d", n, slot);

    // ic held for 20 MCLK starting while slot == 10.
    ic = 1'b1;
    while (n < 223) begin
      tick();
      check_cycle(slot_exp_ic(n), (n >= 211 && n <= 228));
    end
    ic = 1'b0;
    while (n < 242) begin
      tick();
      check_cycle(slot_exp_ic(n), (n >= 211 && n <= 228));
    end
    $display("step ic_hold: n=%0d slot=%0d ic_sync=%0b", n, slot, ic_sync);

    // Single-MCLK ic glitch between c1 pulses: must be ignored.
    ic = 1'b1;
    tick();
    check_cycle(slot_exp_ic(n), 0);
    ic = 1'b0;
    while (n < 332) begin
      tick();
      check_cycle(slot_exp_ic(n), 0);
    end
    $display("step ic_glitch: n=%0d slot=%0d ic_sync=%0b", n, slot, ic_sync);

    // Asynchronous reset at p == 2 with slot == 17.
    chk("pre_reset_slot", slot, 17);
    #2 rst = 1'b1;
    #1;
    chk("rst_c1",        c1,          0);
    chk("rst_c2",        c2,          0);
    chk("rst_slot",      slot,        0);
    chk("rst_slot_last", slot_last,   0);
    chk("rst_ic_sync",   ic_sync,     0);
    chk("rst_c1_sm",     c1_b,        0);
    chk("rst_c2_sm",     c2_b,        0);
    chk("rst_slot_sm",   slot_b,      0);
    $display("step async_reset: slot=%0d c1=%0b c2=%0b", slot, c1, c2);

    // Release again and confirm the timing restarts from scratch.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n   = 0;
    while (n < 60) begin
      tick();
      check_cycle(((n + 2) / 6) % 24, 0);
    end
    $display("step rerun: n=%0d slot=%0d", n, slot);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
